// File: rtl/alu8_seq_ctrl.sv
// Sequential 8-bit ALU: operands latched on accept, one 2-bit slice per cycle
// through a shared slice datapath, result and flags registered on completion.
module alu8_seq_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [1:0] op,
  input  logic       cin,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       cout,
  output logic       ovf,
  output logic       zero
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_XOR = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;

  // Returns {carry into upper bit, carry out, slice result[1:0]}; carries are 0 unless ADD.
  function automatic logic [3:0] slice_eval(input logic [1:0] sa, input logic [1:0] sb,
                                            input logic [1:0] sop, input logic sc);
    logic [1:0] lo;
    logic [1:0] hi;
    lo = 2'b00;
    hi = 2'b00;
    case (sop)
      OP_ADD: begin
        lo = {1'b0, sa[0]} + {1'b0, sb[0]} + {1'b0, sc};
        hi = {1'b0, sa[1]} + {1'b0, sb[1]} + {1'b0, lo[1]};
        slice_eval = {lo[1], hi[1], hi[0], lo[0]};
      end
      OP_XOR:  slice_eval = {2'b00, sa ^ sb};
      OP_AND:  slice_eval = {2'b00, sa & sb};
      default: slice_eval = {2'b00, sa};
    endcase
  endfunction

  state_t     state_r, state_next_s;
  logic       accept_s;
  logic [1:0] idx_r;
  logic       carry_r;
  logic [7:0] acc_r, acc_next_s;
  logic [7:0] a_r, b_r;
  logic [1:0] op_r;
  logic       cin_r;
  logic [2:0] slice_sel_s;
  logic       carry_in_s;
  logic [3:0] slice_s;
  logic       busy_r, done_r, cout_r, ovf_r, zero_r;
  logic [7:0] result_r;

  // Next-state decode and accept detection.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_RUN;
          accept_s     = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (idx_r == 2'd3) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_next_s = ST_RUN;
          accept_s     = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Slice datapath: select the current slice, pick its carry-in, merge into accumulator.
  always_comb begin
    slice_sel_s = {idx_r, 1'b0};
    if (idx_r == 2'd0) begin
      carry_in_s = cin_r;
    end else begin
      carry_in_s = carry_r;
    end
    slice_s    = slice_eval(a_r[slice_sel_s +: 2], b_r[slice_sel_s +: 2], op_r, carry_in_s);
    acc_next_s = acc_r;
    acc_next_s[slice_sel_s +: 2] = slice_s[1:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand latch, slice sequencing and completion registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r      <= 8'h00;
      b_r      <= 8'h00;
      op_r     <= 2'b00;
      cin_r    <= 1'b0;
      idx_r    <= 2'd0;
      carry_r  <= 1'b0;
      acc_r    <= 8'h00;
      result_r <= 8'h00;
      cout_r   <= 1'b0;
      ovf_r    <= 1'b0;
      zero_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      busy_r <= (state_next_s == ST_RUN);
      done_r <= (state_next_s == ST_DONE);
      if (accept_s) begin
        a_r     <= a;
        b_r     <= b;
        op_r    <= op;
        cin_r   <= cin;
        idx_r   <= 2'd0;
        carry_r <= 1'b0;
      end else if (state_r == ST_RUN) begin
        acc_r   <= acc_next_s;
        carry_r <= slice_s[2];
        idx_r   <= idx_r + 2'd1;
        // Slice 3 completes the operation: all outputs update together.
        if (idx_r == 2'd3) begin
          result_r <= acc_next_s;
          cout_r   <= slice_s[2];
          ovf_r    <= slice_s[3] ^ slice_s[2];
          zero_r   <= (acc_next_s == 8'h00);
        end
      end
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;
  assign cout   = cout_r;
  assign ovf    = ovf_r;
  assign zero   = zero_r;

endmodule

// File: tb/tb_alu8_seq_ctrl.sv
// Self-checking bench for alu8_seq_ctrl: directed vector table, randomized ops
// against an arithmetic reference model, plus start-in-RUN and mid-op reset sequences.
module tb_alu8_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a, b;
  logic [1:0] op;
  logic       cin;
  logic       busy, done, cout, ovf, zero;
  logic [7:0] result;

  int total = 0;
  int bad   = 0;

  alu8_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .op(op), .cin(cin),
    .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] va, vb;
    logic [1:0] vop;
    logic       vcin;
    logic [7:0] eres;
    logic       ecout, eovf, ezero;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain 9-bit arithmetic, overflow from operand/result sign rule.
  task automatic model(input logic [7:0] ma, input logic [7:0] mb, input logic [1:0] mop,
                       input logic mcin, output logic [7:0] r, output logic co,
                       output logic ov, output logic z);
    logic [8:0] s;
    co = 1'b0;
    ov = 1'b0;
    case (mop)
      2'b00: begin
        s  = {1'b0, ma} + {1'b0, mb} + {8'h00, mcin};
        r  = s[7:0];
        co = s[8];
        ov = (ma[7] == mb[7]) && (r[7] != ma[7]);
      end
      2'b01:   r = ma ^ mb;
      2'b10:   r = ma & mb;
      default: r = ma;
    endcase
    z = (r == 8'h00);
  endtask

  // Issue one op and follow it to the done cycle; scrambles inputs and start while in flight.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_, input logic [1:0] top,
                       input logic tcin, input logic [7:0] prev_res);
    int busy_cnt;
    busy_cnt = 0;
    @(negedge clk);
    a = ta; b = tb_; op = top; cin = tcin; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); op = 2'($urandom); cin = 1'($urandom);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      check("done_low_run", done, 0);
      check("result_hold", result, prev_res);
      if (k < 4) start = 1'($urandom_range(0, 1));
      else       start = 1'b0;
      a = 8'($urandom); b = 8'($urandom);
    end
    @(negedge clk);
    check("busy_cycles", busy_cnt, 4);
    check("done_pulse", done, 1);
    check("busy_in_done", busy, 0);
  endtask

  task automatic check_outs(input string tag, input logic [7:0] er, input logic ec,
                            input logic eo, input logic ez);
    check({tag, "_result"}, result, er);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_ovf"}, ovf, eo);
    check({tag, "_zero"}, zero, ez);
  endtask

  initial begin
    logic [7:0] prev, er;
    logic ec, eo, ez;
    logic [10:1] done_hist, busy_hist;

    vecs[0] = '{8'h7F, 8'h01, 2'b00, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 2'b00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{8'h01, 8'h01, 2'b00, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{8'hA5, 8'h5A, 2'b01, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{8'hF0, 8'h0F, 2'b10, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'h3C, 8'hFF, 2'b11, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00; op = 2'b00; cin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check_outs("rst", 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Directed vectors.
    prev = 8'h00;
    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i].va, vecs[i].vb, vecs[i].vop, vecs[i].vcin, prev);
      check_outs("vec", vecs[i].eres, vecs[i].ecout, vecs[i].eovf, vecs[i].ezero);
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("result_after_done", result, vecs[i].eres);
      prev = vecs[i].eres;
    end

    // Randomized ops against the reference model.
    for (int n = 0; n < 30; n++) begin
      logic [7:0] ra, rb;
      logic [1:0] rop;
      logic       rc;
      ra = 8'($urandom); rb = 8'($urandom); rop = 2'($urandom); rc = 1'($urandom);
      model(ra, rb, rop, rc, er, ec, eo, ez);
      do_op(ra, rb, rop, rc, prev);
      check_outs("rand", er, ec, eo, ez);
      prev = er;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // start held during RUN is ignored; still high in DONE it accepts the next op.
    @(negedge clk);
    a = 8'h7F; b = 8'h01; op = 2'b00; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    a = 8'h12; b = 8'h34; op = 2'b01; cin = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      done_hist[k] = done;
      busy_hist[k] = busy;
      if (k == 5) begin
        check_outs("b2b_first", 8'h80, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
      end
      if (k == 10) check_outs("b2b_second", 8'h26, 1'b0, 1'b0, 1'b0);
    end
    check("b2b_done_pattern", {22'h0, done_hist}, {22'h0, 10'b10000_10000});
    check("b2b_busy_pattern", {22'h0, busy_hist}, {22'h0, 10'b01111_01111});

    // Reset two cycles into an ADD: outputs clear at once, no done afterwards.
    @(negedge clk);
    a = 8'hFF; b = 8'h01; op = 2'b00; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check_outs("midrst", 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("post_rst_no_done", done, 0);
      check("post_rst_no_busy", busy, 0);
      check("post_rst_result", result, 0);
    end
    do_op(8'h01, 8'h01, 2'b00, 1'b1, 8'h00);
    check_outs("after_rst", 8'h03, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
